// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: opcodes and FSM state encoding for the
// UART-side system controller command decoder.
package sys_ctrl_pkg;

  localparam logic [7:0] OP_WR  = 8'hAA;
  localparam logic [7:0] OP_RD  = 8'hBB;
  localparam logic [7:0] OP_ALU = 8'hCC;
  localparam logic [7:0] OP_NOP = 8'hDD;
  localparam logic [7:0] OP_BWR = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_REQ,
    S_RD_WAIT,
    S_ALU_A,
    S_ALU_B,
    S_ALU_FUN,
    S_ALU_WAIT,
    S_BWR_ADDR,
    S_BWR_CNT,
    S_BWR_DATA,
    S_TX_LO,
    S_TX_HI
  } state_e;

  function automatic logic is_tx(
    input state_e s
  );
    return (s == S_TX_LO) || (s == S_TX_HI);
  endfunction

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// ctrl_timeout_cnt: idle-cycle counter for frame timeout.
// clk/reset(async low), i_clr, i_inc in; o_expire out.
module ctrl_timeout_cnt #(
  parameter int TIMEOUT_W   = 10,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam logic [TIMEOUT_W-1:0] LP_LIM =
    TIMEOUT_W'(TIMEOUT_CYC);

  logic [TIMEOUT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      // saturate so a disabled timeout never wraps
      r_cnt <= r_cnt + TIMEOUT_W'(1);
    end
  end

  assign o_expire = (TIMEOUT_CYC != 0) && i_inc &&
                    (r_cnt == LP_LIM);

endmodule

// File: rtl/sys_ctrl_rx_burst.sv
// sys_ctrl_rx_burst: UART command decoder driving RF, ALU
// and a 2-byte TX handshake; burst writes, timeout, errors.
module sys_ctrl_rx_burst
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int RF_ADDR     = 4,
  parameter int ALU_FUN_W   = 4,
  parameter int TIMEOUT_W   = 10,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   uart_rx_p_data,
  input  logic                    uart_rx_d_vld,
  output logic [RF_ADDR-1:0]      rf_address,
  output logic                    rf_wrEn,
  output logic [DATA_WIDTH-1:0]   rf_wrData,
  output logic                    rf_rdEn,
  input  logic [DATA_WIDTH-1:0]   rf_rdData,
  input  logic                    rf_rdData_vld,
  output logic                    alu_en,
  output logic [ALU_FUN_W-1:0]    alu_fun,
  input  logic [2*DATA_WIDTH-1:0] alu_out,
  input  logic                    alu_out_valid,
  output logic                    clk_gate_en,
  output logic                    clk_div_en,
  output logic                    tx_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  input  logic                    tx_ready,
  output logic                    err_cmd,
  output logic                    err_timeout,
  output logic                    busy
);

  state_e                  r_state;
  state_e                  w_nxt;
  logic [RF_ADDR-1:0]      r_addr;
  logic [DATA_WIDTH-1:0]   r_cnt;
  logic [2*DATA_WIDTH-1:0] r_tx_buf;
  logic                    r_tx_len;
  logic                    w_acc;
  logic                    w_clr;
  logic                    w_inc;
  logic                    w_expire;

  logic [DATA_WIDTH-1:0] w_b;
  logic                  w_v;
  assign w_b = uart_rx_p_data;
  assign w_v = uart_rx_d_vld;

  assign w_inc = (r_state != S_IDLE) &&
                 !is_tx(r_state);
  assign w_clr = (w_nxt != r_state) || w_acc;

  ctrl_timeout_cnt #(
    .TIMEOUT_W  (TIMEOUT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_expire(w_expire)
  );

  assign clk_div_en  = 1'b1;
  assign busy        = (r_state != S_IDLE);
  assign clk_gate_en = (r_state == S_ALU_FUN) ||
                       (r_state == S_ALU_WAIT);

  always_comb begin
    w_nxt       = r_state;
    w_acc       = 1'b0;
    rf_address  = '0;
    rf_wrEn     = 1'b0;
    rf_wrData   = '0;
    rf_rdEn     = 1'b0;
    alu_en      = 1'b0;
    alu_fun     = '0;
    tx_valid    = 1'b0;
    tx_data     = '0;
    err_cmd     = 1'b0;
    err_timeout = 1'b0;
    if (w_expire) begin
      // expiry suppresses any strobe arriving this cycle
      w_nxt       = S_IDLE;
      err_timeout = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_v) begin
          w_acc = 1'b1;
          unique case (1'b1)
            (w_b == DATA_WIDTH'(OP_WR)):
              w_nxt = S_WR_ADDR;
            (w_b == DATA_WIDTH'(OP_RD)):
              w_nxt = S_RD_ADDR;
            (w_b == DATA_WIDTH'(OP_ALU)):
              w_nxt = S_ALU_A;
            (w_b == DATA_WIDTH'(OP_NOP)):
              w_nxt = S_ALU_FUN;
            (w_b == DATA_WIDTH'(OP_BWR)):
              w_nxt = S_BWR_ADDR;
            default:
              err_cmd = 1'b1;
          endcase
        end
        S_WR_ADDR: if (w_v) begin
          w_acc = 1'b1;
          w_nxt = S_WR_DATA;
        end
        S_WR_DATA: begin
          rf_address = r_addr;
          if (w_v) begin
            w_acc     = 1'b1;
            rf_wrEn   = 1'b1;
            rf_wrData = w_b;
            w_nxt     = S_IDLE;
          end
        end
        S_RD_ADDR: if (w_v) begin
          w_acc = 1'b1;
          w_nxt = S_RD_REQ;
        end
        S_RD_REQ: begin
          rf_address = r_addr;
          rf_rdEn    = 1'b1;
          w_nxt = rf_rdData_vld ? S_TX_LO : S_RD_WAIT;
        end
        S_RD_WAIT: begin
          rf_address = r_addr;
          if (rf_rdData_vld) w_nxt = S_TX_LO;
        end
        S_ALU_A: if (w_v) begin
          w_acc     = 1'b1;
          rf_wrEn   = 1'b1;
          rf_wrData = w_b;
          w_nxt     = S_ALU_B;
        end
        S_ALU_B: begin
          rf_address = RF_ADDR'(1);
          if (w_v) begin
            w_acc     = 1'b1;
            rf_wrEn   = 1'b1;
            rf_wrData = w_b;
            w_nxt     = S_ALU_FUN;
          end
        end
        S_ALU_FUN: if (w_v) begin
          w_acc   = 1'b1;
          alu_en  = 1'b1;
          alu_fun = w_b[ALU_FUN_W-1:0];
          w_nxt   = S_ALU_WAIT;
        end
        S_ALU_WAIT: if (alu_out_valid) begin
          w_nxt = S_TX_LO;
        end
        S_BWR_ADDR: if (w_v) begin
          w_acc = 1'b1;
          w_nxt = S_BWR_CNT;
        end
        S_BWR_CNT: if (w_v) begin
          w_acc = 1'b1;
          if (w_b == '0) begin
            err_cmd = 1'b1;
            w_nxt   = S_IDLE;
          end else begin
            w_nxt = S_BWR_DATA;
          end
        end
        S_BWR_DATA: begin
          rf_address = r_addr;
          if (w_v) begin
            w_acc     = 1'b1;
            rf_wrEn   = 1'b1;
            rf_wrData = w_b;
            if (r_cnt == DATA_WIDTH'(1))
              w_nxt = S_IDLE;
          end
        end
        S_TX_LO: begin
          tx_valid = 1'b1;
          tx_data  = r_tx_buf[DATA_WIDTH-1:0];
          if (tx_ready)
            w_nxt = r_tx_len ? S_TX_HI : S_IDLE;
        end
        S_TX_HI: begin
          tx_valid = 1'b1;
          tx_data  = r_tx_buf[2*DATA_WIDTH-1:DATA_WIDTH];
          if (tx_ready) w_nxt = S_IDLE;
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_tx_buf <= '0;
      r_tx_len <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (!w_expire) begin
        unique case (r_state)
          S_WR_ADDR, S_RD_ADDR, S_BWR_ADDR:
            if (w_v) r_addr <= w_b[RF_ADDR-1:0];
          S_BWR_CNT:
            if (w_v) r_cnt <= w_b;
          S_BWR_DATA: if (w_v) begin
            r_addr <= r_addr + RF_ADDR'(1);
            r_cnt  <= r_cnt - DATA_WIDTH'(1);
          end
          S_RD_REQ, S_RD_WAIT: if (rf_rdData_vld) begin
            r_tx_buf <= {{DATA_WIDTH{1'b0}}, rf_rdData};
            r_tx_len <= 1'b0;
          end
          S_ALU_WAIT: if (alu_out_valid) begin
            r_tx_buf <= alu_out;
            r_tx_len <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_ctrl_rx_burst.sv
// tb_sys_ctrl_rx_burst: randomized frames vs. a frame-level
// expectation model; RF/ALU/TX responders in the bench.
module tb_sys_ctrl_rx_burst;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  uart_rx_p_data;
  logic        uart_rx_d_vld;
  logic [3:0]  rf_address;
  logic        rf_wrEn;
  logic [7:0]  rf_wrData;
  logic        rf_rdEn;
  logic [7:0]  rf_rdData;
  logic        rf_rdData_vld;
  logic        alu_en;
  logic [3:0]  alu_fun;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic        clk_gate_en;
  logic        clk_div_en;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        err_cmd;
  logic        err_timeout;
  logic        busy;

  sys_ctrl_rx_burst dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx_p_data(uart_rx_p_data),
    .uart_rx_d_vld (uart_rx_d_vld),
    .rf_address    (rf_address),
    .rf_wrEn       (rf_wrEn),
    .rf_wrData     (rf_wrData),
    .rf_rdEn       (rf_rdEn),
    .rf_rdData     (rf_rdData),
    .rf_rdData_vld (rf_rdData_vld),
    .alu_en        (alu_en),
    .alu_fun       (alu_fun),
    .alu_out       (alu_out),
    .alu_out_valid (alu_out_valid),
    .clk_gate_en   (clk_gate_en),
    .clk_div_en    (clk_div_en),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .err_cmd       (err_cmd),
    .err_timeout   (err_timeout),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  rd_val = 8'h00;
  logic [15:0] alu_val = 16'h0000;
  int          stall_req = 0;
  int          rf_lat;
  int          alu_lat;

  logic [15:0] exp_wr[$];
  logic [15:0] obs_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  obs_rd[$];
  logic [7:0]  exp_alu[$];
  logic [7:0]  obs_alu[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  obs_tx[$];
  int exp_ec = 0;
  int obs_ec = 0;
  int exp_et = 0;
  int obs_et = 0;

  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = 8'h00;

  task automatic chk(
    input string       tag,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, act, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({rf_address, rf_wrEn, rf_wrData,
                rf_rdEn, alu_en, alu_fun,
                clk_gate_en, clk_div_en, tx_valid,
                tx_data, err_cmd, err_timeout, busy});
  endfunction

  // all outputs low except clk_div_en
  localparam logic [63:0] RST_VEC =
    64'({4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0,
         1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});

  always @(negedge clk) begin
    if (rf_wrEn) obs_wr.push_back({4'h0, rf_address, rf_wrData});
    if (rf_rdEn) obs_rd.push_back({4'h0, rf_address});
    if (alu_en) obs_alu.push_back({4'h0, alu_fun});
    if (tx_valid && tx_ready) obs_tx.push_back(tx_data);
    if (err_cmd) obs_ec++;
    if (err_timeout) obs_et++;
    if (stall_pend)
      chk("tx_hold", 64'({tx_valid, tx_data}),
          64'({1'b1, stall_data}));
    stall_pend = tx_valid && !tx_ready;
    stall_data = tx_data;
  end

  always @(negedge clk) begin
    if (rf_rdEn) begin
      rf_lat = $urandom_range(0, 3);
      if (rf_lat == 0) begin
        rf_rdData     = rd_val;
        rf_rdData_vld = 1'b1;
      end else begin
        repeat (rf_lat) @(posedge clk);
        #1;
        rf_rdData     = rd_val;
        rf_rdData_vld = 1'b1;
      end
      @(posedge clk);
      #1;
      rf_rdData_vld = 1'b0;
      rf_rdData     = 8'($urandom);
    end
  end

  always @(negedge clk) begin
    if (alu_en) begin
      alu_lat = $urandom_range(1, 4);
      repeat (alu_lat) @(posedge clk);
      #1;
      alu_out       = alu_val;
      alu_out_valid = 1'b1;
      @(posedge clk);
      #1;
      alu_out_valid = 1'b0;
      alu_out       = 16'($urandom);
    end
  end

  always @(posedge clk) begin
    #1;
    if (tx_valid && stall_req > 0) begin
      tx_ready = 1'b0;
      stall_req--;
    end else begin
      tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic int rgap();
    return $urandom_range(0, 2);
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    uart_rx_p_data = b;
    uart_rx_d_vld  = 1'b1;
    @(posedge clk);
    #1;
    uart_rx_d_vld  = 1'b0;
    uart_rx_p_data = 8'($urandom);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic junk();
    if ($urandom_range(0, 1) == 1) send(8'($urandom), 0);
  endtask

  task automatic cmp_frame(input string tag);
    chk({tag, ":nwr"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      chk({tag, ":wr"}, 64'(obs_wr[i]), 64'(exp_wr[i]));
    chk({tag, ":nrd"}, 64'(obs_rd.size()), 64'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
      chk({tag, ":rd"}, 64'(obs_rd[i]), 64'(exp_rd[i]));
    chk({tag, ":nalu"}, 64'(obs_alu.size()), 64'(exp_alu.size()));
    for (int i = 0; i < exp_alu.size() && i < obs_alu.size(); i++)
      chk({tag, ":alu"}, 64'(obs_alu[i]), 64'(exp_alu[i]));
    chk({tag, ":ntx"}, 64'(obs_tx.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
      chk({tag, ":tx"}, 64'(obs_tx[i]), 64'(exp_tx[i]));
    chk({tag, ":ecmd"}, 64'(obs_ec), 64'(exp_ec));
    chk({tag, ":etmo"}, 64'(obs_et), 64'(exp_et));
    exp_wr.delete();  obs_wr.delete();
    exp_rd.delete();  obs_rd.delete();
    exp_alu.delete(); obs_alu.delete();
    exp_tx.delete();  obs_tx.delete();
    exp_ec = 0; obs_ec = 0;
    exp_et = 0; obs_et = 0;
  endtask

  task automatic finish_frame(input string tag);
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    chk({tag, ":idle"}, 64'(done), 64'(1));
    @(posedge clk);
    #1;
    cmp_frame(tag);
  endtask

  task automatic frame_wr(input logic [3:0] a, input logic [7:0] d);
    exp_wr.push_back({4'h0, a, d});
    send(8'hAA, rgap());
    send({4'h0, a}, rgap());
    send(d, rgap());
    finish_frame("wr");
  endtask

  task automatic frame_rd(input logic [3:0] a, input logic [7:0] v);
    rd_val = v;
    exp_rd.push_back({4'h0, a});
    exp_tx.push_back(v);
    send(8'hBB, rgap());
    send({4'h0, a}, 0);
    junk();
    finish_frame("rd");
  endtask

  task automatic frame_alu(
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] f, input logic [15:0] r
  );
    alu_val = r;
    exp_wr.push_back({8'h00, a});
    exp_wr.push_back({8'h01, b});
    exp_alu.push_back({4'h0, f[3:0]});
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
    send(8'hCC, rgap());
    send(a, rgap());
    send(b, rgap());
    send(f, 0);
    junk();
    finish_frame("alu");
  endtask

  task automatic frame_nop(input logic [7:0] f, input logic [15:0] r);
    alu_val = r;
    exp_alu.push_back({4'h0, f[3:0]});
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
    send(8'hDD, rgap());
    send(f, 0);
    junk();
    finish_frame("nop");
  endtask

  task automatic frame_bwr(input logic [3:0] a, input int n);
    logic [7:0] d;
    send(8'hEE, rgap());
    send({4'h0, a}, rgap());
    send(8'(n), rgap());
    if (n == 0) exp_ec++;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      exp_wr.push_back({4'h0, 4'((a + i) % 16), d});
      send(d, rgap());
    end
    finish_frame("bwr");
  endtask

  task automatic frame_bad(input logic [7:0] op);
    exp_ec++;
    send(op, rgap());
    finish_frame("bad");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op;
    int early;
    uart_rx_p_data = 8'h00;
    uart_rx_d_vld  = 1'b0;
    rf_rdData      = 8'h00;
    rf_rdData_vld  = 1'b0;
    alu_out        = 16'h0000;
    alu_out_valid  = 1'b0;
    tx_ready       = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_out", out_vec(), RST_VEC);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_out", out_vec(), RST_VEC);
    @(posedge clk);
    #1;

    frame_wr(4'h5, 8'h3C);
    frame_rd(4'h5, 8'h3C);
    stall_req = 5;
    frame_alu(8'h12, 8'h34, 8'h01, 16'h0046);
    stall_req = 0;

    exp_wr.push_back({8'h0E, 8'hA1});
    exp_wr.push_back({8'h0F, 8'hA2});
    exp_wr.push_back({8'h00, 8'hA3});
    send(8'hEE, 0); send(8'h0E, 1); send(8'h03, 0);
    send(8'hA1, 2); send(8'hA2, 0); send(8'hA3, 0);
    finish_frame("bwr_wrap");
    frame_bwr(4'h2, 0);
    frame_bad(8'h11);

    exp_et = 1;
    send(8'hAA, 1);
    send(8'h07, 0);
    early = 0;
    for (int j = 0; j < 1000; j++) begin
      @(negedge clk);
      if (err_timeout || !busy) early++;
    end
    chk("tmo_early", 64'(early), 64'(0));
    @(negedge clk);
    chk("tmo_pulse", 64'(err_timeout), 64'(1));
    @(negedge clk);
    chk("tmo_idle", 64'({busy, err_timeout}), 64'(0));
    @(posedge clk);
    #1;
    cmp_frame("tmo");
    frame_wr(4'h7, 8'h55);

    exp_wr.push_back({8'h03, 8'h5A});
    send(8'hEE, 1); send(8'h03, 0);
    send(8'h08, 1); send(8'h5A, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_out", out_vec(), RST_VEC);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cmp_frame("rst_mid");

    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 5))
        0: frame_wr(4'($urandom), 8'($urandom));
        1: frame_rd(4'($urandom), 8'($urandom));
        2: frame_alu(8'($urandom), 8'($urandom),
                     8'($urandom), 16'($urandom));
        3: frame_nop(8'($urandom), 16'($urandom));
        4: frame_bwr(4'($urandom), $urandom_range(0, 6));
        default: begin
          do op = 8'($urandom);
          while (op inside {8'hAA, 8'hBB, 8'hCC,
                            8'hDD, 8'hEE});
          frame_bad(op);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
